// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: multi-cycle WIDTH-bit ALU that reuses one 4-bit slice,
// walking the operands LSB nibble first with a registered carry chain.
`timescale 1ns/1ps
module alu_nibble_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_err
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [2:0] OpPassB = 3'b000;
    localparam logic [2:0] OpAdd   = 3'b010;
    localparam logic [2:0] OpSub   = 3'b011;
    localparam logic [2:0] OpAnd   = 3'b100;
    localparam logic [2:0] OpOr    = 3'b101;
    localparam logic [2:0] OpXor   = 3'b110;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, zero_q, zero_d, err_q, err_d;

    logic [KW+1:0]    bit_sh;
    logic [3:0]       a_nib, b_nib;
    logic [4:0]       slice;
    logic [WIDTH-1:0] result_upd;
    logic             last_nib, op_arith, op_bad;

    // The 4-bit slice; returns {carry_out, y}. Unsupported codes yield zero.
    function automatic logic [4:0] alu4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic [2:0] op);
        logic [4:0] r;
        r = '0;
        case (op)
            OpPassB: r = {1'b0, b};
            OpAdd:   r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
            OpSub:   r = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
            OpAnd:   r = {1'b0, a & b};
            OpOr:    r = {1'b0, a | b};
            OpXor:   r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Slice operand selection and merge of the slice output into the result
    always_comb begin
        bit_sh     = {k_q, 2'b00};
        a_nib      = 4'(a_q >> bit_sh);
        b_nib      = 4'(b_q >> bit_sh);
        slice      = alu4(a_nib, b_nib, carry_q, op_q);
        result_upd = (result_q & ~(WIDTH'(4'hF) << bit_sh)) | (WIDTH'(slice[3:0]) << bit_sh);
        last_nib   = (k_q == KW'(NIB - 1));
        op_arith   = (op_q == OpAdd) || (op_q == OpSub);
        op_bad     = (op_q == 3'b001) || (op_q == 3'b111);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid)  state_d = StRun;
            StRun:   if (last_nib)  state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; data and flags read 0 outside DONE
    always_comb begin
        in_ready   = (state_q == StIdle);
        out_valid  = (state_q == StDone);
        out_result = out_valid ? result_q : '0;
        out_cout   = out_valid & cout_q;
        out_zero   = out_valid & zero_q;
        out_err    = out_valid & err_q;
    end

    // Datapath next-state: load on accept, one nibble per RUN cycle
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        k_d      = k_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    op_d     = in_op;
                    k_d      = '0;
                    // SUB is A + ~B + 1, so the chain starts with carry set
                    carry_d  = (in_op == OpSub);
                    result_d = '0;
                    cout_d   = 1'b0;
                    zero_d   = 1'b0;
                    err_d    = 1'b0;
                end
            end
            StRun: begin
                result_d = result_upd;
                carry_d  = slice[4];
                k_d      = k_q + KW'(1);
                if (last_nib) begin
                    cout_d = op_arith & slice[4];
                    zero_d = (result_upd == '0);
                    err_d  = op_bad;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq at WIDTH=16.
`timescale 1ns/1ps
module tb_alu_nibble_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_result;
    logic [2:0]  in_op;
    logic        out_cout, out_zero, out_err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_nibble_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, check exact latency, result/flags, then complete the handshake
    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] er, input logic ec,
                          input logic ez, input logic ee);
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_res"}, 32'(out_result), 32'(er));
        check_eq({tag, "_cout"}, 32'(out_cout), 32'(ec));
        check_eq({tag, "_zero"}, 32'(out_zero), 32'(ez));
        check_eq({tag, "_err"}, 32'(out_err), 32'(ee));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_vdrop"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rdy2"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 12 && !out_valid; i++) tick();
        check_eq({tag, "_wait"}, 32'(out_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    logic [2:0]  b2b_op  [3] = '{3'b010, 3'b011, 3'b110};
    logic [15:0] b2b_a   [3] = '{16'h0001, 16'h000A, 16'hFFFF};
    logic [15:0] b2b_b   [3] = '{16'h0001, 16'h0003, 16'h00FF};
    logic [15:0] b2b_exp [3] = '{16'h0002, 16'h0007, 16'hFF00};
    int          acc_cyc [3];
    int          nacc, nres, nseen;
    logic        acc_now;

    initial begin
        in_a = '0; in_b = '0; in_op = '0;
        do_reset();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_res", 32'(out_result), 32'd0);
        check_eq("rst_flags", 32'({out_cout, out_zero, out_err}), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);

        run_op("add_ff",   3'b010, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap", 3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("sub_brw",  3'b011, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op("sub_ok",   3'b011, 16'h1234, 16'h0234, 16'h1000, 1'b1, 1'b0, 1'b0);
        run_op("and",      3'b100, 16'hA5C3, 16'h0FF0, 16'h05C0, 1'b0, 1'b0, 1'b0);
        run_op("or",       3'b101, 16'hA5C3, 16'h0FF0, 16'hAFF3, 1'b0, 1'b0, 1'b0);
        run_op("xor",      3'b110, 16'hA5C3, 16'h0FF0, 16'hAA33, 1'b0, 1'b0, 1'b0);
        run_op("passb",    3'b000, 16'hA5C3, 16'h0FF0, 16'h0FF0, 1'b0, 1'b0, 1'b0);
        run_op("bad111",   3'b111, 16'hA5C3, 16'h0FF0, 16'h0000, 1'b0, 1'b1, 1'b1);
        run_op("bad001",   3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1);

        // Backpressure with a pending request that must wait
        in_valid = 1'b1; in_op = 3'b010; in_a = 16'h0001; in_b = 16'h0002;
        tick();
        in_a = 16'h0005; in_b = 16'h0006;
        wait_valid("bp");
        for (int i = 0; i < 6; i++) begin
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_res", 32'(out_result), 32'h0003);
            check_eq("bp_flags", 32'({out_cout, out_zero, out_err}), 32'd0);
            check_eq("bp_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_vdrop", 32'(out_valid), 32'd0);
        check_eq("bp_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_acc", 32'(in_ready), 32'd0);
        wait_valid("bp2");
        check_eq("bp2_res", 32'(out_result), 32'h000B);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back with both handshakes held high
        in_op = b2b_op[0]; in_a = b2b_a[0]; in_b = b2b_b[0];
        in_valid = 1'b1; out_ready = 1'b1;
        nacc = 0; nres = 0;
        for (int cyc = 0; cyc < 40 && nres < 3; cyc++) begin
            acc_now = in_valid && in_ready;
            if (acc_now) acc_cyc[nacc] = cyc;
            if (out_valid) begin
                check_eq("b2b_res", 32'(out_result), 32'(b2b_exp[nres]));
                nres++;
            end
            tick();
            if (acc_now) begin
                nacc++;
                if (nacc < 3) begin
                    in_op = b2b_op[nacc]; in_a = b2b_a[nacc]; in_b = b2b_b[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        check_eq("b2b_nres", 32'(nres), 32'd3);
        check_eq("b2b_nacc", 32'(nacc), 32'd3);
        check_eq("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
        check_eq("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);

        // Reset after two RUN cycles
        in_valid = 1'b1; in_op = 3'b010; in_a = 16'h1111; in_b = 16'h2222;
        tick();
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rr_valid", 32'(out_valid), 32'd0);
        check_eq("rr_res", 32'(out_result), 32'd0);
        check_eq("rr_flags", 32'({out_cout, out_zero, out_err}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        nseen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) nseen++;
        end
        check_eq("rr_noout", 32'(nseen), 32'd0);
        check_eq("rr_ready", 32'(in_ready), 32'd1);
        run_op("rr_add", 3'b010, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0);

        // Reset while holding a result in DONE clears the flags at once
        in_valid = 1'b1; in_op = 3'b010; in_a = 16'hFFFF; in_b = 16'h0001;
        tick();
        in_valid = 1'b0;
        wait_valid("rd");
        check_eq("rd_cz", 32'({out_cout, out_zero}), 32'b11);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rd_valid", 32'(out_valid), 32'd0);
        check_eq("rd_cz0", 32'({out_cout, out_zero, out_err}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check_eq("rd_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end of run");
        $fatal(1);
    end

endmodule
